uart_wb_host: RTL and testbench

- Register-bus initiator that drives a 16550-style UART register slave over its 8-bit bus (addr/dat/we/re; no ack; read data is combinational).
- After reset, and on request, it programs LCR, the divisor latch, FCR and IER.
- It then runs a polling loop on LSR that moves bytes from a valid/ready TX stream into THR, and from RBR into a one-entry RX holding register.
- Used where no CPU is present, for example a debug console bridge.

---
 rtl/uart_wb_host_if.sv | 37 +++
 rtl/uart_wb_host.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_wb_host.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_wb_host_if.sv
// ---------------------------------------------------------------------------
// uart_wb_host_if
// Byte-wide register bus between the uart_wb_host initiator and a
// 16550-style UART register slave. There is no acknowledge. Read data is
// combinational from the slave in the same cycle as the read strobe.
//
//   wb_addr_o  master->slave  register address (ADDR_W bits)
//   wb_dat_o   master->slave  write data
//   wb_we_o    master->slave  one-cycle write strobe
//   wb_re_o    master->slave  one-cycle read strobe
//   wb_dat_i   slave->master  read data, combinational from wb_addr_o
// ---------------------------------------------------------------------------
interface uart_wb_host_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] wb_addr_o;
    logic [7:0]        wb_dat_o;
    logic [7:0]        wb_dat_i;
    logic              wb_we_o;
    logic              wb_re_o;

    modport master (
        output wb_addr_o,
        output wb_dat_o,
        output wb_we_o,
        output wb_re_o,
        input  wb_dat_i
    );

    modport slave (
        input  wb_addr_o,
        input  wb_dat_o,
        input  wb_we_o,
        input  wb_re_o,
        output wb_dat_i
    );
endinterface

// File: rtl/uart_wb_host.sv
// ---------------------------------------------------------------------------
// uart_wb_host
// CPU-less initiator for a 16550-style UART register slave. After reset, or
// after a cfg_load pulse, it programs LCR, the divisor latch, FCR and IER.
// It then polls LSR. Received bytes are moved from RBR into a one-entry
// holding register (rx_data/rx_valid). Bytes from the tx_data/tx_valid
// stream are written to THR, limited by a credit count that is reloaded to
// TX_DEPTH whenever LSR reports THRE.
//
// Ports
//   clk, wb_rst_ni        clock, asynchronous active-low reset
//   bus (master)          register bus: addr/dat_o/we/re out, dat_i in
//   cfg_divisor/lcr/fcr_tl  line configuration, sampled at each init write
//   cfg_load              pulse: rerun the init sequence
//   init_done             init finished, poll loop running
//   tx_data/valid/ready   byte stream to transmit (ready = accept strobe)
//   rx_data/valid/ready   received byte, held until rx_ready
//   rx_err, rx_err_clr    sticky {BI,FE,PE,OE} and its clear
//
// Each access lasts one cycle. It is followed by GAP_CYCLES idle cycles
// with the strobes low and the address held. This spacing lets the slave's
// edge-detected side effects (LSR clear-on-read, RBR pop) fire once, and
// lets DR settle before the next poll.
// ---------------------------------------------------------------------------
module uart_wb_host #(
    parameter int ADDR_W     = 3,
    parameter int TX_DEPTH   = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  wb_rst_ni,
    uart_wb_host_if.master        bus,
    input  logic [15:0]           cfg_divisor,
    input  logic [6:0]            cfg_lcr,
    input  logic [1:0]            cfg_fcr_tl,
    input  logic                  cfg_load,
    output logic                  init_done,
    input  logic [7:0]            tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [3:0]            rx_err,
    input  logic                  rx_err_clr
);

    localparam int               CW          = $clog2(TX_DEPTH + 1);
    localparam logic [CW-1:0]    CREDIT_FULL = CW'(TX_DEPTH);
    localparam logic [2:0]       GAP_LOAD    = 3'(GAP_CYCLES - 1);

    localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(0);  // RBR / THR / DLL
    localparam logic [ADDR_W-1:0] A_IER  = ADDR_W'(1);  // IER / DLM
    localparam logic [ADDR_W-1:0] A_FCR  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_LCR  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_LSR  = ADDR_W'(5);

    localparam logic [3:0] I_LCR1 = 4'd0;
    localparam logic [3:0] I_DLL  = 4'd1;
    localparam logic [3:0] I_DLM  = 4'd2;
    localparam logic [3:0] I_LCR2 = 4'd3;
    localparam logic [3:0] I_FCR  = 4'd4;
    localparam logic [3:0] I_IER  = 4'd5;
    localparam logic [3:0] POLL   = 4'd6;
    localparam logic [3:0] RD_RB  = 4'd7;
    localparam logic [3:0] WR_TR  = 4'd8;
    localparam logic [3:0] GAP    = 4'd9;

    // r_state names the access to issue at the next edge, or GAP. r_ret is
    // the state GAP returns to.
    logic [3:0]        r_state;
    logic [3:0]        r_ret;
    logic [2:0]        r_gap_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_dat;
    logic              r_we;
    logic              r_re;
    logic [CW-1:0]     r_credit;
    logic              r_init_done;
    logic              r_tx_ready;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;
    logic [3:0]        r_rx_err;
    logic              r_load_pend;

    logic              w_lsr_sample;
    logic              w_rb_sample;
    logic [CW-1:0]     w_credit_rl;
    logic [3:0]        w_poll_next;
    logic [3:0]        w_ret;
    logic [3:0]        w_rx_err_next;

    // The read strobe is high only in the cycle after issue. Read data is
    // combinational, so that cycle is when LSR/RBR are sampled.
    assign w_lsr_sample = r_re && (r_addr == A_LSR);
    assign w_rb_sample  = r_re && (r_addr == A_DATA);

    always_comb begin
        w_credit_rl = bus.wb_dat_i[5] ? CREDIT_FULL : r_credit;
        w_poll_next = POLL;
        if (bus.wb_dat_i[0] && !r_rx_valid) begin
            w_poll_next = RD_RB;
        end else if (tx_valid && (w_credit_rl != '0)) begin
            w_poll_next = WR_TR;
        end
        // With GAP_CYCLES=1 the poll decision and the GAP exit share one edge.
        w_ret = w_lsr_sample ? w_poll_next : r_ret;
    end

    // Sticky error bits. A coincident LSR sample wins over the clear.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_err
            assign w_rx_err_next[gi] = (r_rx_err[gi] & ~rx_err_clr)
                                     | (w_lsr_sample & bus.wb_dat_i[gi+1]);
        end
    endgenerate

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= I_LCR1;
            r_ret       <= I_LCR1;
            r_gap_cnt   <= '0;
            r_addr      <= '0;
            r_dat       <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_credit    <= '0;
            r_init_done <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_err    <= '0;
            r_load_pend <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_rx_err    <= w_rx_err_next;
            r_load_pend <= r_load_pend | cfg_load;

            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rb_sample) begin
                r_rx_data  <= bus.wb_dat_i;
                r_rx_valid <= 1'b1;
            end

            // Every access state issues for one cycle and then enters GAP.
            if (r_state != GAP) begin
                r_state   <= GAP;
                r_gap_cnt <= GAP_LOAD;
            end

            case (r_state)
                I_LCR1: begin
                    r_addr <= A_LCR;
                    r_dat  <= {1'b1, cfg_lcr};
                    r_we   <= 1'b1;
                    r_ret  <= I_DLL;
                end
                I_DLL: begin
                    r_addr <= A_DATA;
                    r_dat  <= cfg_divisor[7:0];
                    r_we   <= 1'b1;
                    r_ret  <= I_DLM;
                end
                I_DLM: begin
                    r_addr <= A_IER;
                    r_dat  <= cfg_divisor[15:8];
                    r_we   <= 1'b1;
                    r_ret  <= I_LCR2;
                end
                I_LCR2: begin
                    r_addr <= A_LCR;
                    r_dat  <= {1'b0, cfg_lcr};
                    r_we   <= 1'b1;
                    r_ret  <= I_FCR;
                end
                I_FCR: begin
                    // Enable FIFOs and reset both. The THR FIFO is now empty,
                    // but credit is granted only once LSR reports THRE.
                    r_addr   <= A_FCR;
                    r_dat    <= {cfg_fcr_tl, 3'b000, 2'b11, 1'b1};
                    r_we     <= 1'b1;
                    r_credit <= '0;
                    r_ret    <= I_IER;
                end
                I_IER: begin
                    r_addr <= A_IER;
                    r_dat  <= 8'h00;
                    r_we   <= 1'b1;
                    r_ret  <= POLL;
                end
                POLL: begin
                    r_addr <= A_LSR;
                    r_re   <= 1'b1;
                    r_ret  <= POLL;
                end
                RD_RB: begin
                    r_addr <= A_DATA;
                    r_re   <= 1'b1;
                    r_ret  <= POLL;
                end
                WR_TR: begin
                    r_addr     <= A_DATA;
                    r_dat      <= tx_data;
                    r_we       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_credit   <= r_credit - CW'(1);
                    r_ret      <= POLL;
                end
                GAP: begin
                    if (w_lsr_sample) begin
                        r_ret    <= w_poll_next;
                        r_credit <= w_credit_rl;
                    end
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - 3'd1;
                    end else if (r_load_pend || cfg_load) begin
                        // Reinit only between accesses. The RX holding
                        // register is left intact.
                        r_load_pend <= 1'b0;
                        r_init_done <= 1'b0;
                        r_credit    <= '0;
                        r_state     <= I_LCR1;
                    end else begin
                        r_state <= w_ret;
                        if (w_ret == POLL) begin
                            r_init_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= I_LCR1;
                end
            endcase
        end
    end

    assign bus.wb_addr_o = r_addr;
    assign bus.wb_dat_o  = r_dat;
    assign bus.wb_we_o   = r_we;
    assign bus.wb_re_o   = r_re;
    assign init_done     = r_init_done;
    assign tx_ready      = r_tx_ready;
    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_err        = r_rx_err;

endmodule

// File: tb/tb_uart_wb_host.sv
// ---------------------------------------------------------------------------
// tb_uart_wb_host
// Directed bench for uart_wb_host. A behavioural slave returns bench-chosen
// LSR/RBR values. Expected bus writes are queued when stimulus is applied and
// popped by a monitor as the DUT performs them.
// ---------------------------------------------------------------------------
module tb_uart_wb_host;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic [15:0] cfg_divisor = 16'h0102;
    logic [6:0]  cfg_lcr = 7'h03;
    logic [1:0]  cfg_fcr_tl = 2'b11;
    logic        cfg_load = 1'b0;
    logic        init_done;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [3:0]  rx_err;
    logic        rx_err_clr = 1'b0;

    logic [7:0]  lsr_val = 8'h00;
    logic [7:0]  rb_val = 8'h00;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int tr_cnt = 0;
    int rb_cnt = 0;
    int poll_cnt = 0;
    logic [15:0] exp_q[$];

    uart_wb_host_if #(.ADDR_W(3)) bus ();

    assign bus.wb_dat_i = (bus.wb_addr_o == 3'd5) ? lsr_val : rb_val;

    uart_wb_host #(.ADDR_W(3), .TX_DEPTH(16), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .wb_rst_ni   (wb_rst_ni),
        .bus         (bus),
        .cfg_divisor (cfg_divisor),
        .cfg_lcr     (cfg_lcr),
        .cfg_fcr_tl  (cfg_fcr_tl),
        .cfg_load    (cfg_load),
        .init_done   (init_done),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_err      (rx_err),
        .rx_err_clr  (rx_err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({5'd0, a, d});
    endtask

    // Bus monitor: spacing, scoreboard pop, tx_ready pairing, counters.
    int   last_cyc = 0;
    bit   have_last = 0;
    bit   prev_poll = 0;
    always @(negedge clk) begin
        if (!wb_rst_ni) begin
            have_last = 0;
            prev_poll = 0;
        end else if (bus.wb_we_o || bus.wb_re_o) begin
            if (have_last) check("access_spacing", cyc - last_cyc, GAP + 1);
            have_last = 1;
            last_cyc  = cyc;
            if (bus.wb_we_o) begin
                $display("[%0t] WR addr=%0d dat=%02h tx_ready=%0b", $time,
                         bus.wb_addr_o, bus.wb_dat_o, tx_ready);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", bus.wb_we_o, 1'b0);
                end else begin
                    check("bus_write", {5'd0, bus.wb_addr_o, bus.wb_dat_o}, exp_q.pop_front());
                end
                check("tx_ready_pair", tx_ready, (bus.wb_addr_o == 3'd0) && prev_poll);
                if (bus.wb_addr_o == 3'd0 && prev_poll) tr_cnt++;
            end else begin
                $display("[%0t] RD addr=%0d dat=%02h", $time, bus.wb_addr_o, bus.wb_dat_i);
                if (bus.wb_addr_o == 3'd5) poll_cnt++;
                else if (bus.wb_addr_o == 3'd0) rb_cnt++;
                else check("read_addr", bus.wb_addr_o, 3'd5);
            end
            prev_poll = bus.wb_re_o && (bus.wb_addr_o == 3'd5);
        end
    end

    task automatic wait_tx_ready();
        int n = 0;
        do @(negedge clk); while (!tx_ready && ++n < 200);
        check("tx_ready_seen", tx_ready, 1'b1);
    endtask

    task automatic wait_poll();
        int n = 0;
        do @(negedge clk); while (!(bus.wb_re_o && bus.wb_addr_o == 3'd5) && ++n < 200);
        check("poll_seen", {bus.wb_re_o, bus.wb_addr_o}, {1'b1, 3'd5});
    endtask

    // Present v to exactly one LSR sample, then return LSR to 0.
    task automatic poll_with(input logic [7:0] v);
        wait_poll();
        lsr_val = v;
        @(posedge clk); #1;
        lsr_val = 8'h00;
    endtask

    task automatic wait_init();
        int n = 0;
        do @(negedge clk); while (!init_done && ++n < 300);
        check("init_done_rise", init_done, 1'b1);
    endtask

    task automatic wait_polls(input int k);
        int n = 0;
        int p0 = poll_cnt;
        do begin @(negedge clk); #1; end while (poll_cnt < p0 + k && ++n < 400);
        check("polls_seen", poll_cnt, p0 + k);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tx_data = b;
        tx_valid = 1'b1;
        push_wr(3'd0, b);
        wait_tx_ready();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tr0;
        int rb0;

        // ---- reset state and init sequence ----
        #2;
        check("rst_addr", bus.wb_addr_o, 3'd0);
        check("rst_strobes", {bus.wb_we_o, bus.wb_re_o, bus.wb_dat_o}, 10'd0);
        check("rst_flags", {init_done, tx_ready, rx_valid, rx_err}, 7'd0);
        push_wr(3'd3, 8'h83); push_wr(3'd0, 8'h02); push_wr(3'd1, 8'h01);
        push_wr(3'd3, 8'h03); push_wr(3'd2, 8'hC7); push_wr(3'd1, 8'h00);
        @(negedge clk); @(negedge clk);
        wb_rst_ni = 1'b1;
        @(negedge clk);
        check("first_access", {bus.wb_we_o, bus.wb_addr_o}, {1'b1, 3'd3});
        n = 0;
        do begin @(negedge clk); #1; end while (exp_q.size() != 0 && ++n < 200);
        check("init_writes_done", exp_q.size(), 0);
        @(negedge clk);
        check("init_done_gap1", init_done, 1'b0);
        @(negedge clk);
        check("init_done_gap2", init_done, 1'b1);

        // ---- TX credit: one THRE sample grants 16 writes ----
        tr0 = tr_cnt;
        tx_data = 8'h10; tx_valid = 1'b1; push_wr(3'd0, 8'h10);
        poll_with(8'h60);
        wait_tx_ready();
        @(posedge clk); #1;
        for (int i = 1; i < 16; i++) send_byte(8'h10 + 8'(i));
        tx_data = 8'h20;
        repeat (30) @(posedge clk);
        #1;
        check("tx_credit_stop", tr_cnt, tr0 + 16);
        push_wr(3'd0, 8'h20);
        poll_with(8'h60);
        wait_tx_ready();
        @(posedge clk); #1;
        for (int i = 1; i < 4; i++) send_byte(8'h20 + 8'(i));
        tx_valid = 1'b0;
        check("tx_total", tr_cnt, tr0 + 20);

        // ---- RX priority and hold ----
        rb_val = 8'hA5; lsr_val = 8'h61;
        tx_data = 8'h77; tx_valid = 1'b1; push_wr(3'd0, 8'h77);
        tr0 = tr_cnt; rb0 = rb_cnt;
        n = 0;
        do begin @(negedge clk); #1; end while (rb_cnt == rb0 && ++n < 200);
        check("rb_read", rb_cnt, rb0 + 1);
        check("rb_before_tr", tr_cnt, tr0);
        wait_tx_ready();
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_polls(5);
        check("rb_held_no_reread", rb_cnt, rb0 + 1);
        check("rx_data_a5", rx_data, 8'hA5);
        check("rx_valid_held", rx_valid, 1'b1);
        lsr_val = 8'h00;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        check("rx_valid_clr", rx_valid, 1'b0);

        // ---- sticky errors, set beats clear ----
        poll_with(8'h1E);
        check("rx_err_set", rx_err, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        check("rx_err_sticky", rx_err, 4'hF);
        wait_poll();
        lsr_val = 8'h02;
        rx_err_clr = 1'b1;
        @(posedge clk); #1;
        rx_err_clr = 1'b0;
        lsr_val = 8'h00;
        check("rx_err_clr_set", rx_err, 4'h1);

        // ---- cfg_load during WR_TR ----
        rb_val = 8'h3C;
        poll_with(8'h01);
        repeat (8) @(posedge clk);
        #1;
        check("rx_pre_load", {rx_valid, rx_data}, {1'b1, 8'h3C});
        tx_data = 8'h5A; tx_valid = 1'b1; push_wr(3'd0, 8'h5A);
        wait_tx_ready();
        cfg_load = 1'b1;
        cfg_lcr = 7'h1B; cfg_divisor = 16'h0304; cfg_fcr_tl = 2'b01;
        push_wr(3'd3, 8'h9B); push_wr(3'd0, 8'h04); push_wr(3'd1, 8'h03);
        push_wr(3'd3, 8'h1B); push_wr(3'd2, 8'h47); push_wr(3'd1, 8'h00);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        tx_data = 8'h66;
        tr0 = tr_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("reinit_done_low", init_done, 1'b0);
        wait_init();
        check("reinit_writes", exp_q.size(), 0);
        check("rx_kept", {rx_valid, rx_data}, {1'b1, 8'h3C});
        wait_polls(4);
        check("no_tr_without_credit", tr_cnt, tr0);
        push_wr(3'd0, 8'h66);
        poll_with(8'h60);
        wait_tx_ready();
        @(posedge clk); #1;
        tx_valid = 1'b0;

        // ---- asynchronous reset mid-gap ----
        wait_poll();
        @(posedge clk); #3;
        wb_rst_ni = 1'b0;
        #1;
        check("arst_bus", {bus.wb_addr_o, bus.wb_dat_o, bus.wb_we_o, bus.wb_re_o}, 13'd0);
        check("arst_flags", {init_done, tx_ready, rx_valid, rx_err}, 7'd0);
        check("arst_rx_data", rx_data, 8'h00);
        push_wr(3'd3, 8'h9B); push_wr(3'd0, 8'h04); push_wr(3'd1, 8'h03);
        push_wr(3'd3, 8'h1B); push_wr(3'd2, 8'h47); push_wr(3'd1, 8'h00);
        @(negedge clk); @(negedge clk);
        wb_rst_ni = 1'b1;
        @(negedge clk);
        check("restart_access", {bus.wb_we_o, bus.wb_addr_o, bus.wb_dat_o}, {1'b1, 3'd3, 8'h9B});
        wait_init();
        check("restart_writes", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
